// File: rtl/ibex_pkg.sv
// Shared types for the RVFI trace streamer: the captured retirement record,
// the packet word selector and the header encoder.
package ibex_pkg;

  localparam logic [7:0] TRACE_SYNC = 8'hA5;

  typedef struct packed {
    logic [7:0]  order8;
    logic        trap;
    logic        intr;
    logic [31:0] pc;
    logic [31:0] insn;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic        ovf;
  } trace_rec_t;

  typedef enum logic [2:0] {
    SEL_HDR,
    SEL_PC,
    SEL_INSN,
    SEL_RD,
    SEL_MEM
  } trace_sel_e;

  function automatic logic rec_has_rd(input trace_rec_t rec);
    return rec.rd_addr != 5'd0;
  endfunction

  function automatic logic rec_has_mem(input trace_rec_t rec);
    return (rec.rmask | rec.wmask) != 4'd0;
  endfunction

  function automatic logic [31:0] make_header(input trace_rec_t rec);
    logic [31:0] hdr;
    hdr        = 32'd0;
    hdr[31:24] = TRACE_SYNC;
    hdr[22]    = rec.ovf;
    hdr[21:17] = rec.rd_addr;
    hdr[16:13] = rec.rmask | rec.wmask;
    hdr[12]    = rec.wmask != 4'd0;
    hdr[11]    = rec_has_mem(rec);
    hdr[10]    = rec_has_rd(rec);
    hdr[9]     = rec.intr;
    hdr[8]     = rec.trap;
    hdr[7:0]   = rec.order8;
    return hdr;
  endfunction

endpackage

// File: rtl/ibex_trace_fifo.sv
// Small synchronous FIFO of trace records. The head is read straight from the
// storage registers, so a record written at one edge is visible the next cycle.
module ibex_trace_fifo
  import ibex_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  trace_rec_t data_i,
  input  logic       pop_i,
  output logic       full_o,
  output logic       empty_o,
  output trace_rec_t head_o
);

  localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;

  trace_rec_t     r_mem [Depth];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push_i) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (pop_i) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({push_i, pop_i})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign full_o  = (r_count == (AW+1)'(Depth));
  assign empty_o = (r_count == '0);
  assign head_o  = r_mem[r_rd_ptr];

endmodule

// File: rtl/ibex_trace_streamer.sv
// Captures RVFI retirements into a FIFO and serialises each one into a 3-5 word
// valid/ready packet; records that find the FIFO full are dropped and counted.
module ibex_trace_streamer
  import ibex_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        rvfi_valid,
  input  logic [63:0] rvfi_order,
  input  logic [31:0] rvfi_insn,
  input  logic        rvfi_trap,
  input  logic        rvfi_intr,
  input  logic [31:0] rvfi_pc_rdata,
  input  logic [4:0]  rvfi_rd_addr,
  input  logic [31:0] rvfi_rd_wdata,
  input  logic [31:0] rvfi_mem_addr,
  input  logic [3:0]  rvfi_mem_rmask,
  input  logic [3:0]  rvfi_mem_wmask,
  output logic        trace_valid_o,
  input  logic        trace_ready_i,
  output logic [31:0] trace_data_o,
  output logic        trace_last_o,
  output logic [15:0] drop_cnt_o
);

  trace_sel_e  r_sel;
  trace_sel_e  w_sel_next;
  logic        r_ovf_pending;
  logic [15:0] r_drop_cnt;

  trace_rec_t  w_rec;
  trace_rec_t  w_head;
  logic        w_full;
  logic        w_empty;
  logic        w_push_req;
  logic        w_accept;
  logic        w_drop;
  logic        w_hs;
  logic        w_pop;
  logic        w_last;
  logic [31:0] w_data;
  logic        w_head_has_rd;
  logic        w_head_has_mem;
  logic        w_unused;

  assign w_unused = ^rvfi_order[63:8];

  always_comb begin
    w_rec          = '0;
    w_rec.order8   = rvfi_order[7:0];
    w_rec.trap     = rvfi_trap;
    w_rec.intr     = rvfi_intr;
    w_rec.pc       = rvfi_pc_rdata;
    w_rec.insn     = rvfi_insn;
    w_rec.rd_addr  = rvfi_rd_addr;
    w_rec.rd_wdata = rvfi_rd_wdata;
    w_rec.mem_addr = rvfi_mem_addr;
    w_rec.rmask    = rvfi_mem_rmask;
    w_rec.wmask    = rvfi_mem_wmask;
    w_rec.ovf      = r_ovf_pending;
  end

  // A full FIFO still accepts when its head packet leaves in the same cycle.
  assign w_push_req = enable_i && rvfi_valid;
  assign w_hs       = trace_valid_o && trace_ready_i;
  assign w_pop      = w_hs && w_last;
  assign w_accept   = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && !w_accept;

  ibex_trace_fifo #(
    .Depth (Depth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_accept),
    .data_i  (w_rec),
    .pop_i   (w_pop),
    .full_o  (w_full),
    .empty_o (w_empty),
    .head_o  (w_head)
  );

  assign w_head_has_rd  = rec_has_rd(w_head);
  assign w_head_has_mem = rec_has_mem(w_head);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sel <= SEL_HDR;
    end else begin
      r_sel <= w_sel_next;
    end
  end

  always_comb begin
    w_sel_next = r_sel;
    w_data     = 32'd0;
    w_last     = 1'b0;
    case (r_sel)
      SEL_HDR: begin
        w_data = make_header(w_head);
        if (w_hs) w_sel_next = SEL_PC;
      end
      SEL_PC: begin
        w_data = w_head.pc;
        if (w_hs) w_sel_next = SEL_INSN;
      end
      SEL_INSN: begin
        w_data = w_head.insn;
        w_last = !w_head_has_rd && !w_head_has_mem;
        if (w_hs) begin
          if (w_head_has_rd)       w_sel_next = SEL_RD;
          else if (w_head_has_mem) w_sel_next = SEL_MEM;
          else                     w_sel_next = SEL_HDR;
        end
      end
      SEL_RD: begin
        w_data = w_head.rd_wdata;
        w_last = !w_head_has_mem;
        if (w_hs) w_sel_next = w_head_has_mem ? SEL_MEM : SEL_HDR;
      end
      SEL_MEM: begin
        w_data = w_head.mem_addr;
        w_last = 1'b1;
        if (w_hs) w_sel_next = SEL_HDR;
      end
      default: begin
        w_sel_next = SEL_HDR;
      end
    endcase
  end

  // The overflow flag rides on the next record that makes it into the FIFO.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ovf_pending <= 1'b0;
      r_drop_cnt    <= 16'd0;
    end else begin
      if (w_drop) begin
        r_ovf_pending <= 1'b1;
        if (r_drop_cnt != 16'hFFFF) begin
          r_drop_cnt <= r_drop_cnt + 16'd1;
        end
      end else if (w_accept) begin
        r_ovf_pending <= 1'b0;
      end
    end
  end

  assign trace_valid_o = !w_empty;
  assign trace_data_o  = w_empty ? 32'd0 : w_data;
  assign trace_last_o  = !w_empty && w_last;
  assign drop_cnt_o    = r_drop_cnt;

endmodule
